orion_mem_arbiter: RTL and testbench
====================================

Name: orion_mem_arbiter

Overview:
- Shares one unified memory port between the IF stage (instruction fetch, read-only) and the MEM stage (loads/stores).
- Fixed data-over-instruction priority, with a starvation guard so fetch always makes progress.
- Grant is registered and held until the slave acks; one transaction is outstanding at a time.
- Sits between the core pipeline and the memory/cache port, using the valid/ack bus with addr, rdata, wdata, mask, we.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while an instruction request waits; 0 disables the guard (pure data priority).
- CNT_W, $clog2(STARVE_LIMIT+1) (min 1): width of the streak counter; derived, not overridden.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- imem_valid  in  1  fetch request; held stable until imem_ack
- imem_addr  in  ADDRW  fetch address
- imem_rdata  out  DATAW  fetch read data, valid when imem_ack
- imem_ack  out  1  fetch complete
- dmem_valid  in  1  data request; held stable until dmem_ack
- dmem_addr  in  ADDRW  data address
- dmem_we  in  1  1 = store
- dmem_mask  in  MASKW  byte mask
- dmem_wdata  in  DATAW  store data
- dmem_rdata  out  DATAW  load data, valid when dmem_ack
- dmem_ack  out  1  data complete
- mem_valid  out  1  request to memory
- mem_addr  out  ADDRW  muxed address
- mem_we  out  1  muxed write enable (0 for fetch)
- mem_mask  out  MASKW  muxed mask (all ones for fetch)
- mem_wdata  out  DATAW  muxed write data (0 for fetch)
- mem_rdata  in  DATAW  memory read data
- mem_ack  in  1  memory complete
- arb_busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- Reset (async, rst_n=0): state=IDLE and streak=0. All outputs are 0: mem_valid, mem_we, mem_mask, mem_addr, mem_wdata, acks, rdata, arb_busy.
- Reset mid-transaction aborts immediately. The slave must tolerate the dropped valid.
- FSM states: IDLE, GNT_I, GNT_D (encoded as enum arb_state_t).
- IDLE:
  - If a starvation event is pending (STARVE_LIMIT>0, streak==STARVE_LIMIT, imem_valid): go to GNT_I.
  - Else if dmem_valid: go to GNT_D.
  - Else if imem_valid: go to GNT_I.
  - Else stay in IDLE.
- GNT_x:
  - mem_valid=1. mem_* are muxed combinationally from master x inputs.
  - Stay until mem_ack=1, then go to IDLE on the next edge.
- Ack routing:
  - In the mem_ack cycle, x_ack=mem_ack and x_rdata=mem_rdata, combinational pass-through to the granted master only.
  - The other master's ack=0 and its rdata=0.
- Latency:
  - Request seen in IDLE at cycle 0 → mem_valid at cycle 1.
  - mem_ack at cycle k → master ack at cycle k.
  - The arbiter is back in IDLE at k+1, so there is one bubble between back-to-back transactions.
- Streak counter (updated on the IDLE→GNT transition):
  - Grant D while imem_valid=1: streak += 1, saturating at STARVE_LIMIT.
  - Grant D while imem_valid=0: streak=0.
  - Grant I: streak=0.
- mem_ack while in IDLE is ignored, with no ack to either master.
- A master deasserting valid before its ack is a protocol violation: flagged by an assertion, behaviour undefined.
- Simultaneous requests in IDLE resolve as listed above; a request never retires within the cycle it is first seen.

Optional Feature:
- ORION_ARB_RR_EN
- Defined: pure round-robin. A last_grant flop is reset to I, so data wins the first tie. On simultaneous requests, grant goes to the master not granted last. The streak counter and STARVE_LIMIT are unused; the counter is tied to 0.
- Undefined: fixed data priority plus the starvation guard described above.

Decomposition:
- Add to the shared types package:
  - arb_state_t enum (IDLE=2'b00, GNT_I=2'b01, GNT_D=2'b10).
  - Packed struct mem_req_t {addr, we, mask, wdata, valid}, used for both master request bundles and the mux.
- Sub-module orion_arb_pick: combinational grant decision. Inputs: imem_valid, dmem_valid, starvation flag, last_grant. Output: next grant. It isolates the ifdef'd policy.

Test Plan:
- Single fetch: imem_valid, addr=0x100; mem_ack at cycle 3 with rdata=0xDEADBEEF → mem_valid at cycle 1, mem_we=0, mem_mask=4'hF; imem_ack/imem_rdata=0xDEADBEEF at cycle 3; dmem_ack=0 throughout.
- Store: dmem addr=0x2000, we=1, mask=4'b0011, wdata=0x1234 → mem_* carry those exact values; dmem_ack mirrors mem_ack; arb_busy=1 from cycle 1 until the ack cycle.
- Contention, RR off, STARVE_LIMIT=4: both masters request continuously, 1-cycle ack → grant order D,D,D,D,I,D,D,D,D,I…
- Contention with ORION_ARB_RR_EN: same stimulus → D,I,D,I…
- Reset mid-transaction: rst_n=0 while in GNT_D → mem_valid, acks and arb_busy drop the same cycle. After release, a pending imem_valid is granted (streak cleared).
- Spurious ack: mem_ack=1 in IDLE with no requests → no master ack, state stays IDLE.

Source files
------------

// File: rtl/orion_mem_arbiter_pkg.sv
// Shared types for the orion memory arbiter: FSM states, grant history and request bundle.
package orion_mem_arbiter_pkg;

    localparam int ADDRW = 32;
    localparam int DATAW = 32;
    localparam int MASKW = DATAW / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } arb_state_t;

    typedef enum logic {
        LAST_I = 1'b0,
        LAST_D = 1'b1
    } grant_t;

    typedef struct packed {
        logic [ADDRW-1:0] addr;
        logic             we;
        logic [MASKW-1:0] mask;
        logic [DATAW-1:0] wdata;
        logic             valid;
    } mem_req_t;

    // A limit of zero still needs a one-bit counter so the port widths stay legal.
    function automatic int streak_width(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/orion_arb_pick.sv
// Combinational grant decision for the memory arbiter.
// ORION_ARB_RR_EN selects round-robin; otherwise fixed data priority with a starvation override.
module orion_arb_pick
    import orion_mem_arbiter_pkg::*;
(
    input  logic       imem_valid,
    input  logic       dmem_valid,
    input  logic       starve,
    input  grant_t     last_grant,
    output arb_state_t next_grant
);

`ifdef ORION_ARB_RR_EN
    logic unused_starve;
    assign unused_starve = starve;

    always_comb begin
        next_grant = IDLE;
        if (imem_valid && dmem_valid) begin
            next_grant = (last_grant == LAST_D) ? GNT_I : GNT_D;
        end else if (dmem_valid) begin
            next_grant = GNT_D;
        end else if (imem_valid) begin
            next_grant = GNT_I;
        end
    end
`else
    grant_t unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        next_grant = IDLE;
        if (starve && imem_valid) begin
            next_grant = GNT_I;
        end else if (dmem_valid) begin
            next_grant = GNT_D;
        end else if (imem_valid) begin
            next_grant = GNT_I;
        end
    end
`endif

endmodule

// File: rtl/orion_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction at a time.
// Define ORION_ARB_RR_EN for round-robin arbitration instead of data priority with starvation guard.
module orion_mem_arbiter
    import orion_mem_arbiter_pkg::*;
#(
    parameter int  STARVE_LIMIT = 4,
    localparam int CNT_W        = streak_width(STARVE_LIMIT)
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             imem_valid,
    input  logic [ADDRW-1:0] imem_addr,
    output logic [DATAW-1:0] imem_rdata,
    output logic             imem_ack,

    input  logic             dmem_valid,
    input  logic [ADDRW-1:0] dmem_addr,
    input  logic             dmem_we,
    input  logic [MASKW-1:0] dmem_mask,
    input  logic [DATAW-1:0] dmem_wdata,
    output logic [DATAW-1:0] dmem_rdata,
    output logic             dmem_ack,

    output logic             mem_valid,
    output logic [ADDRW-1:0] mem_addr,
    output logic             mem_we,
    output logic [MASKW-1:0] mem_mask,
    output logic [DATAW-1:0] mem_wdata,
    input  logic [DATAW-1:0] mem_rdata,
    input  logic             mem_ack,

    output logic             arb_busy
);

    arb_state_t       state, state_nxt, pick;
    logic [CNT_W-1:0] streak, streak_nxt;
    grant_t           last_grant, last_grant_nxt;
    logic             starve;
    mem_req_t         ireq, dreq, mux;

    // Fetches are always full-width reads.
    assign ireq = '{addr: imem_addr, we: 1'b0, mask: {MASKW{1'b1}}, wdata: {DATAW{1'b0}}, valid: imem_valid};
    assign dreq = '{addr: dmem_addr, we: dmem_we, mask: dmem_mask, wdata: dmem_wdata, valid: dmem_valid};

    assign starve = (STARVE_LIMIT > 0) && (streak == CNT_W'(STARVE_LIMIT));

    orion_arb_pick u_pick (
        .imem_valid (imem_valid),
        .dmem_valid (dmem_valid),
        .starve     (starve),
        .last_grant (last_grant),
        .next_grant (pick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            streak     <= '0;
            last_grant <= LAST_I;
        end else begin
            state      <= state_nxt;
            streak     <= streak_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // The streak only moves when a new grant is issued from IDLE.
    always_comb begin
        state_nxt      = state;
        streak_nxt     = streak;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                state_nxt = pick;
                if (pick == GNT_D) begin
                    last_grant_nxt = LAST_D;
`ifdef ORION_ARB_RR_EN
                    streak_nxt = '0;
`else
                    if (!imem_valid) begin
                        streak_nxt = '0;
                    end else if (!starve) begin
                        streak_nxt = streak + CNT_W'(1);
                    end
`endif
                end else if (pick == GNT_I) begin
                    last_grant_nxt = LAST_I;
                    streak_nxt     = '0;
                end
            end
            GNT_I, GNT_D: begin
                if (mem_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mux        = '0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        case (state)
            GNT_I: begin
                mux        = ireq;
                mux.valid  = 1'b1;
                imem_ack   = mem_ack;
                imem_rdata = mem_ack ? mem_rdata : '0;
            end
            GNT_D: begin
                mux        = dreq;
                mux.valid  = 1'b1;
                dmem_ack   = mem_ack;
                dmem_rdata = mem_ack ? mem_rdata : '0;
            end
            default: ;
        endcase
    end

    assign mem_valid = mux.valid;
    assign mem_addr  = mux.addr;
    assign mem_we    = mux.we;
    assign mem_mask  = mux.mask;
    assign mem_wdata = mux.wdata;
    assign arb_busy  = (state != IDLE);

`ifndef SYNTHESIS
    // A granted master must keep its request up until the slave completes it.
    a_imem_held: assert property (@(posedge clk) disable iff (!rst_n) (state == GNT_I) |-> ireq.valid);
    a_dmem_held: assert property (@(posedge clk) disable iff (!rst_n) (state == GNT_D) |-> dreq.valid);
`endif

endmodule

// File: tb/tb_orion_mem_arbiter.sv
// Randomized self-checking bench for orion_mem_arbiter against a transaction-level model,
// plus directed fetch/store/contention/reset/spurious-ack scenarios.
module tb_orion_mem_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        dmem_valid;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [3:0]  dmem_mask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_mask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        arb_busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: who owns the bus (0 none, 1 fetch, 2 data), data grants given to a waiting fetch, last winner.
    int m_owner  = 0;
    int m_streak = 0;
    int m_last   = 1;
    int m_pick;

    logic [70:0] exp_bus;
    logic [32:0] exp_i, exp_d;
    logic        prev_mv = 1'b0;
    bit          rec_en  = 1'b0;
    string       dut_seq = "";
    string       mdl_seq = "";
    string       letter;

    bit i_seen = 1'b0, d_seen = 1'b0;
    int wait_cnt = 0, lat = 0;

    always #5 clk = ~clk;

    orion_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_valid (imem_valid),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .dmem_valid (dmem_valid),
        .dmem_addr  (dmem_addr),
        .dmem_we    (dmem_we),
        .dmem_mask  (dmem_mask),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_mask   (mem_mask),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .arb_busy   (arb_busy)
    );

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_seq(input string name, input string act, input string exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %s, expected %s", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle comparison against the model, then advance the model with this cycle's inputs.
    always @(negedge clk) begin
        if (!rst_n) begin
            check_output("reset_outputs",
                         {mem_valid, mem_addr, mem_we, mem_mask, mem_wdata, arb_busy,
                          imem_ack, imem_rdata, dmem_ack, dmem_rdata}, '0);
            m_owner  = 0;
            m_streak = 0;
            m_last   = 1;
        end else begin
            exp_bus = '0;
            exp_i   = '0;
            exp_d   = '0;
            if (m_owner == 1) begin
                exp_bus = {1'b1, imem_addr, 1'b0, 4'hF, 32'h0, 1'b1};
                exp_i   = {mem_ack, mem_ack ? mem_rdata : 32'h0};
            end else if (m_owner == 2) begin
                exp_bus = {1'b1, dmem_addr, dmem_we, dmem_mask, dmem_wdata, 1'b1};
                exp_d   = {mem_ack, mem_ack ? mem_rdata : 32'h0};
            end
            check_output("bus", {mem_valid, mem_addr, mem_we, mem_mask, mem_wdata, arb_busy}, exp_bus);
            check_output("imem_resp", {imem_ack, imem_rdata}, exp_i);
            check_output("dmem_resp", {dmem_ack, dmem_rdata}, exp_d);

            if (rec_en && mem_valid && !prev_mv) begin
                letter  = (mem_addr == 32'h2000) ? "D" : "I";
                dut_seq = {dut_seq, letter};
            end

            if (m_owner != 0) begin
                if (mem_ack) m_owner = 0;
            end else begin
                m_pick = 0;
`ifdef ORION_ARB_RR_EN
                if (imem_valid && dmem_valid) m_pick = (m_last == 2) ? 1 : 2;
                else if (dmem_valid)          m_pick = 2;
                else if (imem_valid)          m_pick = 1;
                if (m_pick != 0) m_streak = 0;
`else
                if (LIMIT > 0 && m_streak >= LIMIT && imem_valid) m_pick = 1;
                else if (dmem_valid)                              m_pick = 2;
                else if (imem_valid)                              m_pick = 1;
                if (m_pick == 2) m_streak = imem_valid ? ((m_streak + 1 > LIMIT) ? LIMIT : m_streak + 1) : 0;
                if (m_pick == 1) m_streak = 0;
`endif
                if (m_pick != 0) begin
                    m_owner = m_pick;
                    m_last  = m_pick;
                    if (rec_en) mdl_seq = {mdl_seq, (m_pick == 2) ? "D" : "I"};
                end
            end
        end
        prev_mv = mem_valid;
    end

    // One cycle of random masters plus a slave with 0..3 wait states and occasional spurious acks.
    task automatic apply_stimulus(input bit allow_new);
        tick();
        if (i_seen || !imem_valid) begin
            imem_valid = allow_new && ($urandom_range(0, 99) < 40);
            imem_addr  = $urandom() & 32'h0000_FFFC;
        end
        if (d_seen || !dmem_valid) begin
            dmem_valid = allow_new && ($urandom_range(0, 99) < 70);
            dmem_addr  = $urandom() & 32'h0001_FFFC;
            dmem_we    = $urandom_range(0, 1) == 1;
            dmem_mask  = 4'($urandom_range(0, 15));
            dmem_wdata = $urandom();
        end
        if (mem_valid) begin
            if (wait_cnt >= lat) begin
                mem_ack   = 1'b1;
                mem_rdata = $urandom();
                wait_cnt  = 0;
                lat       = $urandom_range(0, 3);
            end else begin
                mem_ack  = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ack   = ($urandom_range(0, 9) == 0);
            mem_rdata = $urandom();
            wait_cnt  = 0;
        end
        #1;
        i_seen = imem_ack;
        d_seen = dmem_ack;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        imem_valid = 1'b0;
        imem_addr  = '0;
        dmem_valid = 1'b0;
        dmem_addr  = '0;
        dmem_we    = 1'b0;
        dmem_mask  = '0;
        dmem_wdata = '0;
        mem_rdata  = '0;
        mem_ack    = 1'b0;
        repeat (2) tick();
        check_output("reset_idle", {mem_valid, arb_busy, imem_ack, dmem_ack}, 4'b0000);
        rst_n = 1'b1;

        // Single fetch, ack three cycles after the request.
        tick();
        imem_valid = 1'b1;
        imem_addr  = 32'h100;
        tick();
        check_output("fetch_c1_bus", {mem_valid, mem_addr, mem_we, mem_mask, arb_busy}, {1'b1, 32'h100, 1'b0, 4'hF, 1'b1});
        tick();
        check_output("fetch_c2_acks", {imem_ack, dmem_ack}, 2'b00);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        #1;
        check_output("fetch_c3_ack", {imem_ack, imem_rdata, dmem_ack}, {1'b1, 32'hDEADBEEF, 1'b0});
        tick();
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        imem_valid = 1'b0;
        check_output("fetch_done_idle", {mem_valid, arb_busy}, 2'b00);

        // Partial-width store.
        tick();
        dmem_valid = 1'b1;
        dmem_addr  = 32'h2000;
        dmem_we    = 1'b1;
        dmem_mask  = 4'b0011;
        dmem_wdata = 32'h1234;
        tick();
        check_output("store_bus", {mem_valid, mem_addr, mem_we, mem_mask, mem_wdata, arb_busy},
                     {1'b1, 32'h2000, 1'b1, 4'b0011, 32'h1234, 1'b1});
        check_output("store_no_ack_yet", {dmem_ack, imem_ack}, 2'b00);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h55;
        #1;
        check_output("store_ack", {dmem_ack, dmem_rdata, imem_ack, arb_busy}, {1'b1, 32'h55, 1'b0, 1'b1});
        tick();
        mem_ack    = 1'b0;
        dmem_valid = 1'b0;
        dmem_we    = 1'b0;
        check_output("store_done_idle", arb_busy, 1'b0);

        // Spurious acks while idle.
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        repeat (3) begin
            #1;
            check_output("spurious_ack", {imem_ack, dmem_ack, arb_busy, imem_rdata, dmem_rdata}, '0);
            tick();
        end
        mem_ack = 1'b0;
        check_output("spurious_still_idle", {mem_valid, arb_busy}, 2'b00);

        // Reset while a store is in flight with a fetch waiting.
        tick();
        dmem_valid = 1'b1;
        dmem_addr  = 32'h2000;
        dmem_we    = 1'b0;
        dmem_mask  = 4'hF;
        imem_valid = 1'b1;
        imem_addr  = 32'h300;
        tick();
        check_output("rst_mid_granted_d", {mem_valid, mem_addr}, {1'b1, 32'h2000});
        mem_ack   = 1'b1;
        mem_rdata = 32'hA5;
        #1;
        check_output("rst_mid_ack_before", dmem_ack, 1'b1);
        rst_n = 1'b0;
        #1;
        check_output("rst_mid_drop", {mem_valid, dmem_ack, imem_ack, arb_busy}, 4'b0000);
        mem_ack    = 1'b0;
        dmem_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_output("rst_mid_fetch_after", {mem_valid, mem_addr, mem_we}, {1'b1, 32'h300, 1'b0});
        mem_ack = 1'b1;
        tick();
        mem_ack    = 1'b0;
        imem_valid = 1'b0;

        // Continuous contention with single-cycle acks.
        rst_n = 1'b0;
        tick();
        rst_n      = 1'b1;
        rec_en     = 1'b1;
        imem_valid = 1'b1;
        imem_addr  = 32'h100;
        dmem_valid = 1'b1;
        dmem_addr  = 32'h2000;
        dmem_we    = 1'b0;
        dmem_mask  = 4'hF;
        dmem_wdata = '0;
        for (int c = 0; c < 200 && dut_seq.len() < 10; c++) begin
            tick();
            mem_ack   = mem_valid;
            mem_rdata = $urandom();
        end
        tick();
        rec_en     = 1'b0;
        mem_ack    = 1'b0;
        imem_valid = 1'b0;
        dmem_valid = 1'b0;
        check_output("contention_grants_seen", dut_seq.len() >= 10, 1'b1);
`ifdef ORION_ARB_RR_EN
        check_seq("contention_order_dut", dut_seq.substr(0, 9), "DIDIDIDIDI");
        check_seq("contention_order_model", mdl_seq.substr(0, 9), "DIDIDIDIDI");
`else
        check_seq("contention_order_dut", dut_seq.substr(0, 9), "DDDDIDDDDI");
        check_seq("contention_order_model", mdl_seq.substr(0, 9), "DDDDIDDDDI");
`endif

        // Randomized traffic, then drain outstanding requests.
        rst_n = 1'b0;
        tick();
        rst_n  = 1'b1;
        i_seen = 1'b0;
        d_seen = 1'b0;
        for (int c = 0; c < 3000; c++) apply_stimulus(1'b1);
        for (int c = 0; c < 200 && (imem_valid || dmem_valid); c++) apply_stimulus(1'b0);
        check_output("drain_complete", {imem_valid, dmem_valid}, 2'b00);
        mem_ack = 1'b0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
